// File: rtl/drive_pkg.sv
// Shared types for the motor drive sequencer: direction encoding,
// channel and supervisor state enums, and counter widths.
package drive_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;

  // PWM counter width covers periods up to 65536; duty needs one extra bit
  // so that a full-period duty (100%) is representable.
  localparam int CNT_W  = 16;
  localparam int DUTY_W = 17;

  typedef enum logic [1:0] {OFF, DEAD, DRIVE} ch_state_t;
  typedef enum logic [1:0] {OK, FAULT_WAIT, LOCKOUT} sup_state_t;

  // 2'b11 is treated as coast, same as 2'b00
  function automatic logic [1:0] dir_norm(input logic [1:0] d);
    return (d == DIR_FWD || d == DIR_REV) ? d : DIR_COAST;
  endfunction

endpackage

// File: rtl/motor_drive_sequencer_if.sv
// Steering-command / H-bridge-pin bundle of the motor drive sequencer.
// master = steering side (drives commands), slave = sequencer.
interface motor_drive_sequencer_if;
  logic [1:0]  cmd_dir_l;
  logic [1:0]  cmd_dir_r;
  logic [15:0] cmd_duty_l;
  logic [15:0] cmd_duty_r;
  logic        oc_n;
  logic        fault_clr;
  logic        en_l;
  logic        en_r;
  logic        fwd_l;
  logic        bwd_l;
  logic        fwd_r;
  logic        bwd_r;
  logic        fault;
  logic        lockout;
  logic [1:0]  retry_cnt;

  modport master (
    output cmd_dir_l, cmd_dir_r, cmd_duty_l, cmd_duty_r, oc_n, fault_clr,
    input  en_l, en_r, fwd_l, bwd_l, fwd_r, bwd_r, fault, lockout, retry_cnt
  );

  modport slave (
    input  cmd_dir_l, cmd_dir_r, cmd_duty_l, cmd_duty_r, oc_n, fault_clr,
    output en_l, en_r, fwd_l, bwd_l, fwd_r, bwd_r, fault, lockout, retry_cnt
  );
endinterface

// File: rtl/hbridge_channel.sv
// One H-bridge side: polarity FSM with dead-time insertion, duty clamp and
// period-aligned duty sampling, registered en/fwd/bwd.
//
//   state | meaning
//   OFF   | bridge idle, all outputs low
//   DEAD  | both-off interval counting down toward target direction dir_q
//   DRIVE | polarity dir_q asserted, en follows the PWM compare
module hbridge_channel
  import drive_pkg::*;
#(
  parameter int PWM_PERIOD  = 32768,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd_dir,
  input  logic [15:0]      cmd_duty,
  input  logic [CNT_W-1:0] pwm_cnt,
  input  logic             force_off,
  output logic             en,
  output logic             fwd,
  output logic             bwd
);

  localparam int DC_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [DC_W-1:0]   DEAD_LOAD = DC_W'(DEAD_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PWM_PERIOD);

  ch_state_t         state;
  logic [1:0]        dir_q;
  logic [DC_W-1:0]   dead_cnt;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_clamped;
  logic [DUTY_W-1:0] duty_eff;
  logic [1:0]        cmd_n;
  logic              pwm_on;

  assign cmd_n        = dir_norm(cmd_dir);
  assign duty_clamped = ({1'b0, cmd_duty} > DUTY_MAX) ? DUTY_MAX : {1'b0, cmd_duty};
  // at the period start the freshly sampled duty already governs this cycle
  assign duty_eff     = (pwm_cnt == '0) ? duty_clamped : duty_q;
  assign pwm_on       = ({1'b0, pwm_cnt} < duty_eff);

  // duty only changes at the PWM wrap so a period is never cut short
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                duty_q <= '0;
    else if (pwm_cnt == '0) duty_q <= duty_clamped;
  end

  // polarity FSM; outputs registered from the next-state decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      dir_q    <= DIR_COAST;
      dead_cnt <= '0;
      en       <= 1'b0;
      fwd      <= 1'b0;
      bwd      <= 1'b0;
    end else begin
      en  <= 1'b0;
      fwd <= 1'b0;
      bwd <= 1'b0;
      if (force_off) begin
        state    <= OFF;
        dir_q    <= DIR_COAST;
        dead_cnt <= '0;
      end else begin
        case (state)
          OFF: begin
            if (cmd_n != DIR_COAST) begin
              state    <= DEAD;
              dir_q    <= cmd_n;
              dead_cnt <= DEAD_LOAD;
            end
          end
          DEAD: begin
            if (cmd_n != dir_q) begin
              dir_q    <= cmd_n;
              dead_cnt <= DEAD_LOAD;
            end else if (dead_cnt == '0) begin
              if (dir_q == DIR_COAST) begin
                state <= OFF;
              end else begin
                state <= DRIVE;
                fwd   <= (dir_q == DIR_FWD);
                bwd   <= (dir_q == DIR_REV);
                en    <= pwm_on;
              end
            end else begin
              dead_cnt <= dead_cnt - 1'b1;
            end
          end
          DRIVE: begin
            if (cmd_n != dir_q) begin
              state    <= DEAD;
              dir_q    <= cmd_n;
              dead_cnt <= DEAD_LOAD;
            end else begin
              fwd <= (dir_q == DIR_FWD);
              bwd <= (dir_q == DIR_REV);
              en  <= pwm_on;
            end
          end
          default: begin
            state <= OFF;
            dir_q <= DIR_COAST;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_drive_sequencer.sv
// Drives both H-bridge sides from steering commands. Holds the shared PWM
// counter, the overcurrent synchronizer/filter and the retry/lockout
// supervisor; per-side sequencing lives in hbridge_channel.
//
//   state      | meaning
//   OK         | normal operation, clean-run timer may clear retry_cnt
//   FAULT_WAIT | overcurrent seen, bridges held off for RETRY_CYCLES
//   LOCKOUT    | retry budget spent, held off until fault_clr
module motor_drive_sequencer
  import drive_pkg::*;
#(
  parameter int PWM_PERIOD   = 32768,
  parameter int DEAD_CYCLES  = 1000,
  parameter int OC_FILTER    = 100,
  parameter int RETRY_CYCLES = 50_000_000,
  parameter int MAX_RETRIES  = 3
) (
  input logic                    clk,
  input logic                    rst,
  motor_drive_sequencer_if.slave bus
);

  localparam int FLT_W = $clog2(OC_FILTER + 1);
  localparam int RT_W  = $clog2(RETRY_CYCLES + 1);
  localparam logic [RT_W-1:0] RT_LOAD = RT_W'(RETRY_CYCLES - 1);

  logic             oc_s1;
  logic             oc_s2;
  logic [FLT_W-1:0] flt_cnt;
  logic             oc_trip;
  logic [CNT_W-1:0] pwm_cnt;
  sup_state_t       sup_state;
  logic [RT_W-1:0]  hold_cnt;
  logic [RT_W-1:0]  clean_cnt;
  logic [1:0]       retry_cnt;
  logic             fault_q;
  logic             lockout_q;
  logic             clr_ok;
  logic             force_off;

  // comparator is asynchronous; idle level is high so reset to high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_s1 <= 1'b1;
      oc_s2 <= 1'b1;
    end else begin
      oc_s1 <= bus.oc_n;
      oc_s2 <= oc_s1;
    end
  end

  // count consecutive low samples, saturating at the trip threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              flt_cnt <= '0;
    else if (oc_s2)                       flt_cnt <= '0;
    else if (flt_cnt != FLT_W'(OC_FILTER)) flt_cnt <= flt_cnt + 1'b1;
  end

  assign oc_trip = (flt_cnt == FLT_W'(OC_FILTER));
  // a trip always wins over a simultaneous clear request
  assign clr_ok  = bus.fault_clr & ~oc_trip;
  // the trip itself must blank the bridges on the same edge fault rises
  assign force_off = (sup_state != OK) | oc_trip;

  // shared PWM time base
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  pwm_cnt <= '0;
    else if (pwm_cnt == CNT_W'(PWM_PERIOD - 1)) pwm_cnt <= '0;
    else                                      pwm_cnt <= pwm_cnt + 1'b1;
  end

  // overcurrent supervisor with timed retry, clean-run reset and lockout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sup_state <= OK;
      hold_cnt  <= '0;
      clean_cnt <= '0;
      retry_cnt <= '0;
      fault_q   <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      case (sup_state)
        OK: begin
          if (oc_trip) begin
            sup_state <= FAULT_WAIT;
            hold_cnt  <= RT_LOAD;
            fault_q   <= 1'b1;
            if (retry_cnt != 2'd3) retry_cnt <= retry_cnt + 1'b1;
          end else if (clean_cnt == '0) begin
            retry_cnt <= '0;
          end else begin
            clean_cnt <= clean_cnt - 1'b1;
          end
        end
        FAULT_WAIT: begin
          if (hold_cnt == '0) begin
            clean_cnt <= RT_LOAD;
            if (retry_cnt == 2'(MAX_RETRIES)) begin
              sup_state <= LOCKOUT;
              lockout_q <= 1'b1;
            end else begin
              sup_state <= OK;
              fault_q   <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        LOCKOUT: begin
          if (clr_ok) begin
            sup_state <= OK;
            clean_cnt <= RT_LOAD;
            fault_q   <= 1'b0;
            lockout_q <= 1'b0;
          end
        end
        default: begin
          sup_state <= OK;
          fault_q   <= 1'b0;
          lockout_q <= 1'b0;
        end
      endcase
      if (clr_ok) retry_cnt <= '0;
    end
  end

  hbridge_channel #(
    .PWM_PERIOD  (PWM_PERIOD),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_ch_l (
    .clk       (clk),
    .rst       (rst),
    .cmd_dir   (bus.cmd_dir_l),
    .cmd_duty  (bus.cmd_duty_l),
    .pwm_cnt   (pwm_cnt),
    .force_off (force_off),
    .en        (bus.en_l),
    .fwd       (bus.fwd_l),
    .bwd       (bus.bwd_l)
  );

  hbridge_channel #(
    .PWM_PERIOD  (PWM_PERIOD),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_ch_r (
    .clk       (clk),
    .rst       (rst),
    .cmd_dir   (bus.cmd_dir_r),
    .cmd_duty  (bus.cmd_duty_r),
    .pwm_cnt   (pwm_cnt),
    .force_off (force_off),
    .en        (bus.en_r),
    .fwd       (bus.fwd_r),
    .bwd       (bus.bwd_r)
  );

  assign bus.fault     = fault_q;
  assign bus.lockout   = lockout_q;
  assign bus.retry_cnt = retry_cnt;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Self-checking bench for motor_drive_sequencer: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a run-length / timestamp based behavioural model.
module tb_motor_drive_sequencer;

  localparam int P  = 16;
  localparam int D  = 4;
  localparam int F  = 3;
  localparam int RC = 20;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motor_drive_sequencer_if ifc ();

  motor_drive_sequencer #(
    .PWM_PERIOD   (P),
    .DEAD_CYCLES  (D),
    .OC_FILTER    (F),
    .RETRY_CYCLES (RC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A side drives direction d once the command has been d, with the
  // supervisor not blanking, for DEAD+1 consecutive edges.
  int m_pos;
  int m_duty [2];
  int m_run  [2];
  int m_rdir [2];
  int lowrun;
  int lowrun_q[$];
  bit m_wait, m_lock, m_fault_prev;
  int m_wait_end, m_ok_since, m_retries, m_n;
  bit e_en [2], e_fwd [2], e_bwd [2];
  bit e_fault, e_lock;
  int e_retry;

  always @(posedge clk or posedge rst) begin
    bit trip, clr, fault_now, forced;
    int eff, drv, duty, cmd;
    if (rst) begin
      m_pos = 0; m_n = 0; lowrun = 0;
      lowrun_q = '{0, 0, 0};
      m_wait = 0; m_lock = 0; m_fault_prev = 0;
      m_wait_end = 0; m_ok_since = -1000; m_retries = 0;
      for (int s = 0; s < 2; s++) begin
        m_duty[s] = 0; m_run[s] = 0; m_rdir[s] = 0;
        e_en[s] = 0; e_fwd[s] = 0; e_bwd[s] = 0;
      end
      e_fault = 0; e_lock = 0; e_retry = 0;
    end else begin
      m_n++;
      // filter sees the comparator two edges late; trip when the low run
      // that ended three edges ago reached the threshold
      lowrun = (ifc.oc_n == 1'b0) ? lowrun + 1 : 0;
      lowrun_q.push_back(lowrun);
      trip = (lowrun_q[0] >= F);
      void'(lowrun_q.pop_front());
      clr = ifc.fault_clr;

      if (m_lock) begin
        if (clr && !trip) begin m_lock = 0; m_ok_since = m_n; end
      end else if (m_wait) begin
        if (m_n == m_wait_end) begin
          m_wait = 0;
          if (m_retries == MR) m_lock = 1;
          else m_ok_since = m_n;
        end
      end else begin
        if (trip) begin
          m_wait = 1;
          m_wait_end = m_n + RC;
          m_retries = (m_retries < 3) ? m_retries + 1 : 3;
        end else if (m_n - m_ok_since >= RC) begin
          m_retries = 0;
        end
      end
      if (clr && !trip) m_retries = 0;

      fault_now = m_wait || m_lock;
      forced = m_fault_prev || fault_now;
      m_fault_prev = fault_now;

      for (int s = 0; s < 2; s++) begin
        cmd  = (s == 0) ? int'(ifc.cmd_dir_l) : int'(ifc.cmd_dir_r);
        duty = (s == 0) ? int'(ifc.cmd_duty_l) : int'(ifc.cmd_duty_r);
        eff  = (cmd == 1) ? 1 : (cmd == 2) ? 2 : 0;
        if (forced || eff == 0) begin
          m_run[s] = 0; m_rdir[s] = 0;
        end else if (eff == m_rdir[s]) begin
          if (m_run[s] < 1000) m_run[s]++;
        end else begin
          m_rdir[s] = eff; m_run[s] = 1;
        end
        drv = (m_run[s] >= D + 1) ? m_rdir[s] : 0;
        if (m_pos == 0) m_duty[s] = (duty > P) ? P : duty;
        e_fwd[s] = (drv == 1);
        e_bwd[s] = (drv == 2);
        e_en[s]  = (drv != 0) && (m_pos < m_duty[s]);
      end
      m_pos = (m_pos + 1) % P;

      e_fault = fault_now;
      e_lock  = m_lock;
      e_retry = m_retries;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("en_l",      int'(ifc.en_l),      int'(e_en[0]));
    chk("fwd_l",     int'(ifc.fwd_l),     int'(e_fwd[0]));
    chk("bwd_l",     int'(ifc.bwd_l),     int'(e_bwd[0]));
    chk("en_r",      int'(ifc.en_r),      int'(e_en[1]));
    chk("fwd_r",     int'(ifc.fwd_r),     int'(e_fwd[1]));
    chk("bwd_r",     int'(ifc.bwd_r),     int'(e_bwd[1]));
    chk("fault",     int'(ifc.fault),     int'(e_fault));
    chk("lockout",   int'(ifc.lockout),   int'(e_lock));
    chk("retry_cnt", int'(ifc.retry_cnt), e_retry);
    chk("overlap_l", int'(ifc.fwd_l & ifc.bwd_l), 0);
    chk("overlap_r", int'(ifc.fwd_r & ifc.bwd_r), 0);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_en_l(input int k, output int n);
    n = 0;
    repeat (k) begin
      tick(1);
      if (ifc.en_l) n++;
    end
  endtask

  int n;
  int burst;
  int duty_tab [8] = '{0, 3, 8, 15, 16, 17, 40, 65535};

  initial begin
    ifc.cmd_dir_l = 2'b00; ifc.cmd_dir_r = 2'b00;
    ifc.cmd_duty_l = '0;   ifc.cmd_duty_r = '0;
    ifc.oc_n = 1'b1;       ifc.fault_clr = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("reset fwd_l",  int'(ifc.fwd_l), 0);
    chk("reset en_l",   int'(ifc.en_l), 0);
    chk("reset fault",  int'(ifc.fault), 0);
    chk("reset retry",  int'(ifc.retry_cnt), 0);
    rst = 1'b0;

    // forward with 50% duty
    ifc.cmd_dir_l = 2'b01; ifc.cmd_duty_l = 16'd8;
    tick(4);
    chk("fwd_l during dead", int'(ifc.fwd_l), 0);
    tick(1);
    chk("fwd_l after 5 edges", int'(ifc.fwd_l), 1);
    tick(20);
    count_en_l(16, n);
    chk("en_l high per period duty8", n, 8);

    // polarity reversal
    ifc.cmd_dir_l = 2'b10;
    tick(1);
    chk("fwd_l drops next edge", int'(ifc.fwd_l | ifc.bwd_l), 0);
    n = 0;
    repeat (3) begin
      tick(1);
      if (ifc.fwd_l | ifc.bwd_l) n++;
    end
    chk("dead cycles nonzero", n, 0);
    tick(1);
    chk("bwd_l rises", int'(ifc.bwd_l), 1);

    // duty boundaries
    ifc.cmd_duty_l = 16'd0;
    tick(32); count_en_l(16, n);
    chk("en_l duty0", n, 0);
    ifc.cmd_duty_l = 16'd16;
    tick(32); count_en_l(16, n);
    chk("en_l duty16", n, 16);
    ifc.cmd_duty_l = 16'd40;
    tick(32); count_en_l(16, n);
    chk("en_l duty40", n, 16);

    // short glitch ignored
    ifc.oc_n = 1'b0; tick(2); ifc.oc_n = 1'b1;
    tick(10);
    chk("no fault on 2-cycle glitch", int'(ifc.fault), 0);

    // real fault, retry 1
    ifc.oc_n = 1'b0; tick(3); ifc.oc_n = 1'b1;
    tick(2);
    chk("fault not yet at edge 5", int'(ifc.fault), 0);
    tick(1);
    chk("fault at edge 6", int'(ifc.fault), 1);
    chk("bwd_l off on fault", int'(ifc.bwd_l | ifc.en_l), 0);
    chk("retry 1", int'(ifc.retry_cnt), 1);
    tick(19);
    chk("fault held", int'(ifc.fault), 1);
    tick(1);
    chk("fault released", int'(ifc.fault), 0);
    tick(4);
    chk("bwd_l still in dead", int'(ifc.bwd_l), 0);
    tick(1);
    chk("bwd_l resumes", int'(ifc.bwd_l), 1);

    // second fault inside clean window -> lockout
    ifc.oc_n = 1'b0; tick(3); ifc.oc_n = 1'b1;
    tick(3);
    chk("second fault", int'(ifc.fault), 1);
    chk("retry 2", int'(ifc.retry_cnt), 2);
    tick(20);
    chk("lockout entered", int'(ifc.lockout), 1);
    tick(30);
    chk("lockout held", int'(ifc.lockout), 1);
    chk("lockout fault", int'(ifc.fault), 1);
    ifc.fault_clr = 1'b1; tick(1); ifc.fault_clr = 1'b0;
    chk("clr exits lockout", int'(ifc.lockout | ifc.fault), 0);
    chk("clr zeroes retry", int'(ifc.retry_cnt), 0);

    // clear coincident with trip: trip wins
    ifc.oc_n = 1'b0; tick(3); ifc.oc_n = 1'b1;
    tick(2);
    ifc.fault_clr = 1'b1; tick(1); ifc.fault_clr = 1'b0;
    chk("trip beats clr fault", int'(ifc.fault), 1);
    chk("trip beats clr retry", int'(ifc.retry_cnt), 1);
    tick(30);
    chk("bwd_l driving again", int'(ifc.bwd_l), 1);

    // asynchronous reset mid-drive
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("async rst bwd_l", int'(ifc.bwd_l | ifc.en_l), 0);
    chk("async rst retry", int'(ifc.retry_cnt), 0);
    tick(1); rst = 1'b0;
    tick(4);
    chk("post-rst dead", int'(ifc.bwd_l), 0);
    tick(1);
    chk("post-rst drive", int'(ifc.bwd_l), 1);

    // randomized phase
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) ifc.cmd_dir_l = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) ifc.cmd_dir_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) ifc.cmd_duty_l = 16'(duty_tab[$urandom_range(0, 7)]);
      if ($urandom_range(0, 29) == 0) ifc.cmd_duty_r = 16'(duty_tab[$urandom_range(0, 7)]);
      if (burst > 0) begin
        ifc.oc_n = 1'b0; burst--;
      end else begin
        ifc.oc_n = 1'b1;
        if ($urandom_range(0, 59) == 0) burst = $urandom_range(1, 6);
      end
      ifc.fault_clr = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    ifc.fault_clr = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
